ping_pong_monitor: RTL

- Observer at the consuming end of the ping-pong counter's (out, direction) interface.
- Samples the counter's registered out/direction stream, checks every cycle-to-cycle transition for protocol legality, counts bounces, and captures turning points (peak/valley).
- Used on-board for status LEDs and in benches as a self-checking scoreboard for any ping-pong counter instance.

---
 rtl/ping_pong_monitor_if.sv | 34 +++
 rtl/ping_pong_monitor.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ping_pong_monitor_if.sv
// Observation bus between a ping-pong counter and its monitor.
// The master side drives the counter's (out, direction) sample stream.
// The slave side is the monitor, which returns its status outputs.
interface ping_pong_monitor_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  // Sample stream from the counter under observation
  logic             in_valid;
  logic [WIDTH-1:0] in_out;
  logic             in_dir;

  // Monitor status
  logic [CNT_W-1:0] bounce_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             step_err;
  logic [WIDTH-1:0] peak;
  logic             peak_vld;
  logic [WIDTH-1:0] valley;
  logic             valley_vld;
  logic [1:0]       state;

  modport master (
    output in_valid, in_out, in_dir,
    input  bounce_cnt, err_cnt, step_err, peak, peak_vld,
           valley, valley_vld, state
  );

  modport slave (
    input  in_valid, in_out, in_dir,
    output bounce_cnt, err_cnt, step_err, peak, peak_vld,
           valley, valley_vld, state
  );
endinterface

// File: rtl/ping_pong_monitor.sv
// Ping-pong counter monitor.
// Watches the registered (out, direction) stream of a ping-pong counter,
// flags every illegal cycle-to-cycle transition, counts legal reversals
// and captures the most recent turning points (peak and valley).
// All outputs are registered; a sample taken on an edge is reflected in
// the outputs right after that same edge.
module ping_pong_monitor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  ping_pong_monitor_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  // Saturating increment: all-ones is sticky until reset or clear.
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] res;
    if (v == {CNT_W{1'b1}}) begin
      res = v;
    end else begin
      res = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  // Registered state
  state_t           r_state;
  logic [WIDTH-1:0] r_prev_out;
  logic             r_prev_dir;
  logic [CNT_W-1:0] r_bounce_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_step_err;
  logic [WIDTH-1:0] r_peak;
  logic             r_peak_vld;
  logic [WIDTH-1:0] r_valley;
  logic             r_valley_vld;

  // Transition classification against the previous accepted sample
  logic [WIDTH-1:0] w_prev_inc;
  logic [WIDTH-1:0] w_prev_dec;
  logic             w_hold;
  logic             w_step_up;
  logic             w_step_dn;
  logic             w_legal;
  logic             w_bounce;

  // Classify the incoming sample; neighbour values wrap modulo 2^WIDTH.
  always_comb begin
    w_prev_inc = r_prev_out + {{(WIDTH-1){1'b0}}, 1'b1};
    w_prev_dec = r_prev_out - {{(WIDTH-1){1'b0}}, 1'b1};
    w_hold     = (bus.in_out == r_prev_out) && (bus.in_dir == r_prev_dir);
    w_step_up  = (bus.in_dir == 1'b1) && (bus.in_out == w_prev_inc);
    w_step_dn  = (bus.in_dir == 1'b0) && (bus.in_out == w_prev_dec);
    w_legal    = w_hold || w_step_up || w_step_dn;
    // A hold never changes direction, so a direction change here is a step.
    w_bounce   = w_legal && (bus.in_dir != r_prev_dir);
  end

  // Monitor FSM: reset/clear, sample acceptance, checking and counting.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      // Clear has the same effect as reset; a sample arriving with it is dropped.
      r_state      <= ST_IDLE;
      r_prev_out   <= {WIDTH{1'b0}};
      r_prev_dir   <= 1'b0;
      r_bounce_cnt <= {CNT_W{1'b0}};
      r_err_cnt    <= {CNT_W{1'b0}};
      r_step_err   <= 1'b0;
      r_peak       <= {WIDTH{1'b0}};
      r_peak_vld   <= 1'b0;
      r_valley     <= {WIDTH{1'b0}};
      r_valley_vld <= 1'b0;
    end else begin
      // step_err is a one-cycle pulse; only an illegal sample raises it.
      r_step_err <= 1'b0;
      if (bus.in_valid) begin
        case (r_state)
          ST_IDLE: begin
            // First sample after reset/clear only seeds the history.
            r_step_err <= 1'b0;
          end
          ST_UP, ST_DOWN: begin
            if (w_legal) begin
              if (w_bounce) begin
                r_bounce_cnt <= f_sat_inc(r_bounce_cnt);
                if (r_prev_dir) begin
                  r_peak     <= r_prev_out;
                  r_peak_vld <= 1'b1;
                end else begin
                  r_valley     <= r_prev_out;
                  r_valley_vld <= 1'b1;
                end
              end else begin
                r_bounce_cnt <= r_bounce_cnt;
              end
            end else begin
              r_step_err <= 1'b1;
              r_err_cnt  <= f_sat_inc(r_err_cnt);
            end
          end
          default: begin
            // Unreachable encoding: behave like IDLE and resynchronise.
            r_step_err <= 1'b0;
          end
        endcase
        // Every accepted sample, legal or not, becomes the new reference.
        r_prev_out <= bus.in_out;
        r_prev_dir <= bus.in_dir;
        r_state    <= bus.in_dir ? ST_UP : ST_DOWN;
      end else begin
        r_state <= r_state;
      end
    end
  end

  // Drive the status bus straight from registers.
  assign bus.bounce_cnt = r_bounce_cnt;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.step_err   = r_step_err;
  assign bus.peak       = r_peak;
  assign bus.peak_vld   = r_peak_vld;
  assign bus.valley     = r_valley;
  assign bus.valley_vld = r_valley_vld;
  assign bus.state      = r_state;

endmodule
